// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32I core front end
package core_pkg;
  localparam int XLEN = 32;
  localparam int IMEM_ADDR_W = 7;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with hold, sequential advance and redirect load
import core_pkg::*;
module pc_reg #(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk)
    pc <= rst ? RESET_PC : load ? target : advance ? pc + ADDR_W'(INSTR_BYTES) : pc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC ownership, imem addressing and a single registered slot to decode
import core_pkg::*;
module fetch_stage #(
  parameter int ADDR_W = 7,
  parameter int XLEN = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  output logic [ADDR_W-1:0] r_addr_imem,
  input  logic [XLEN-1:0]   r_data_imem,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              misalign_err,
  output logic [31:0]       fetch_count,
  output logic [1:0]        state_o
);
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_stage: RESET_PC must be word-aligned");
  end
  fetch_state_t state, state_next;
  logic [ADDR_W-1:0] pc;
  logic redir, aligned, load, fetch_en;
  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .advance(fetch_en), .load(load), .target(redirect_pc), .pc(pc)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_next;
  always_comb begin
    state_next = state;
    if (state == IDLE && run_en) state_next = RUN;
    if (state == RUN && redirect_valid && !aligned) state_next = HALT;
  end
  // redirect outranks fetch, so a redirecting cycle never advances pc
  always_comb begin
    redir = state == RUN && redirect_valid;
    aligned = redirect_pc[1:0] == 2'b00;
    load = redir && aligned;
    fetch_en = state == RUN && !redirect_valid && (!out_valid || out_ready);
    r_addr_imem = pc;
    state_o = state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc <= '0;
      misalign_err <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (out_valid && out_ready) fetch_count <= fetch_count + 32'd1;
      if (redir && !aligned) misalign_err <= 1'b1;
      if (state != RUN || redirect_valid) out_valid <= 1'b0;
      else if (fetch_en) begin
        out_valid <= 1'b1;
        out_instr <= r_data_imem;
        out_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed values
module tb_fetch_stage;
  logic clk = 0, rst = 1, run_en = 0, redirect_valid = 0, out_ready = 1;
  logic [6:0] redirect_pc = '0, r_addr_imem, out_pc;
  logic [31:0] r_data_imem, out_instr, fetch_count;
  logic out_valid, misalign_err;
  logic [1:0] state_o;
  logic [31:0] mem [32];
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  assign r_data_imem = mem[r_addr_imem[6:2]];
  fetch_stage dut (
    .clk(clk), .rst(rst), .run_en(run_en), .r_addr_imem(r_addr_imem), .r_data_imem(r_data_imem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .misalign_err(misalign_err),
    .fetch_count(fetch_count), .state_o(state_o)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00a0_0113;
    step(); step();
    rst = 0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", 32'(out_pc), 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_err", 32'(misalign_err), 0);
    chk("rst_addr", 32'(r_addr_imem), 0);
    run_en = 1;
    step();
    chk("run_state", 32'(state_o), 1);
    chk("run_valid0", 32'(out_valid), 0);
    step();
    run_en = 0;
    chk("f0_valid", 32'(out_valid), 1);
    chk("f0_pc", 32'(out_pc), 0);
    chk("f0_instr", out_instr, 32'h0050_0093);
    chk("f0_addr", 32'(r_addr_imem), 4);
    step();
    chk("f1_pc", 32'(out_pc), 4);
    chk("f1_instr", out_instr, 32'h00a0_0113);
    chk("f1_count", fetch_count, 1);
    step();
    chk("f2_pc", 32'(out_pc), 8);
    chk("f2_count", fetch_count, 2);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(out_pc), 8);
      chk("stall_instr", out_instr, 32'hC0DE_0008);
      chk("stall_addr", 32'(r_addr_imem), 32'h0C);
      chk("stall_count", fetch_count, 2);
    end
    out_ready = 1;
    step();
    chk("resume_pc", 32'(out_pc), 32'h0C);
    chk("resume_instr", out_instr, 32'hC0DE_000C);
    chk("resume_count", fetch_count, 3);
    step();
    chk("f4_pc", 32'(out_pc), 32'h10);
    redirect_valid = 1;
    redirect_pc = 7'h40;
    step();
    redirect_valid = 0;
    chk("redir_count", fetch_count, 5);
    chk("redir_valid", 32'(out_valid), 0);
    chk("redir_addr", 32'(r_addr_imem), 32'h40);
    step();
    chk("tgt_valid", 32'(out_valid), 1);
    chk("tgt_pc", 32'(out_pc), 32'h40);
    chk("tgt_instr", out_instr, 32'hC0DE_0040);
    redirect_valid = 1;
    redirect_pc = 7'h7C;
    step();
    redirect_valid = 0;
    chk("wrap_redir_count", fetch_count, 6);
    step();
    chk("wrap_pc7c", 32'(out_pc), 32'h7C);
    chk("wrap_instr", out_instr, 32'hC0DE_007C);
    chk("wrap_addr0", 32'(r_addr_imem), 0);
    step();
    chk("wrap_pc0", 32'(out_pc), 0);
    chk("wrap_addr4", 32'(r_addr_imem), 4);
    chk("wrap_count", fetch_count, 7);
    redirect_valid = 1;
    redirect_pc = 7'h22;
    step();
    chk("mis_err", 32'(misalign_err), 1);
    chk("mis_state", 32'(state_o), 2);
    chk("mis_valid", 32'(out_valid), 0);
    chk("mis_addr", 32'(r_addr_imem), 4);
    chk("mis_count", fetch_count, 8);
    redirect_pc = 7'h40;
    step();
    redirect_valid = 0;
    chk("halt_state", 32'(state_o), 2);
    chk("halt_addr", 32'(r_addr_imem), 4);
    chk("halt_valid", 32'(out_valid), 0);
    chk("halt_outpc", 32'(out_pc), 0);
    step();
    chk("halt_hold", 32'(state_o), 2);
    rst = 1;
    step();
    rst = 0;
    chk("hrst_err", 32'(misalign_err), 0);
    chk("hrst_state", 32'(state_o), 0);
    chk("hrst_addr", 32'(r_addr_imem), 0);
    run_en = 1;
    step();
    run_en = 0;
    step();
    chk("s_valid", 32'(out_valid), 1);
    chk("s_pc", 32'(out_pc), 0);
    step();
    out_ready = 0;
    chk("s_pc4", 32'(out_pc), 4);
    chk("s_count", fetch_count, 1);
    step();
    chk("s_hold", 32'(out_pc), 4);
    rst = 1;
    step();
    rst = 0;
    out_ready = 1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_instr", out_instr, 0);
    chk("mrst_pc", 32'(out_pc), 0);
    chk("mrst_count", fetch_count, 0);
    chk("mrst_state", 32'(state_o), 0);
    chk("mrst_addr", 32'(r_addr_imem), 0);
    redirect_valid = 1;
    redirect_pc = 7'h40;
    step();
    redirect_valid = 0;
    chk("idle_redir_addr", 32'(r_addr_imem), 0);
    chk("idle_redir_state", 32'(state_o), 0);
    chk("idle_redir_valid", 32'(out_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I core. It sits directly upstream of the byte-addressed instruction memory.
- It owns the program counter and drives the memory read address. The memory returns a little-endian 32-bit word combinationally, in the same cycle.
- Each fetched word and its PC are registered into a single pipeline slot that feeds decode over a valid/ready handshake.
- Branch/jump redirects from execute flush the slot and reload the PC.

Parameters:
- ADDR_W, 7, width of instruction byte address (128-byte memory)
- XLEN, 32, instruction/data word width
- RESET_PC, 0, PC value loaded on reset; must be word-aligned

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- run_en  input  1  leave IDLE and begin fetching
- r_addr_imem  output  ADDR_W  byte address to instruction memory (equals pc)
- r_data_imem  input  XLEN  instruction word from memory, valid same cycle
- redirect_valid  input  1  execute requests PC change
- redirect_pc  input  ADDR_W  redirect target byte address
- out_valid  output  1  out_instr/out_pc hold a valid instruction
- out_ready  input  1  decode accepts this cycle
- out_instr  output  XLEN  registered instruction
- out_pc  output  ADDR_W  byte address of out_instr
- misalign_err  output  1  sticky: redirect target not word-aligned
- fetch_count  output  32  number of instructions accepted by decode
- state_o  output  2  current FSM state (debug)

Behaviour:
- Reset (rst=1 at clk edge), regardless of state or in-flight transfer:
  - pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0
  - misalign_err=0, fetch_count=0, state=IDLE
- r_addr_imem = pc, combinationally, in every state.
- FSM states: IDLE=0, RUN=1, HALT=2.
  - IDLE: no fetch; out_valid stays 0. run_en=1 moves to RUN next cycle; the first fetch happens in the first RUN cycle.
  - RUN: fetch_en = !out_valid || out_ready.
    - On fetch_en: out_instr<=r_data_imem, out_pc<=pc, out_valid<=1, pc<=pc+4.
    - Fetch-to-output latency is 1 cycle; throughput is 1 instruction/cycle while out_ready=1.
  - Stall: when out_valid=1 and out_ready=0, out_instr, out_pc, out_valid and pc all hold.
  - HALT: entered from RUN only on a misaligned redirect. out_valid=0; pc, out_instr and out_pc hold; redirects are ignored. Only rst exits HALT.
- Redirect (RUN only, redirect_valid=1) has priority over fetch in the same cycle:
  - Aligned target (redirect_pc[1:0]==0): pc<=redirect_pc and out_valid<=0. No fetch that cycle; the target word is fetched the following cycle.
  - Misaligned target: misalign_err<=1, out_valid<=0, state<=HALT; pc unchanged.
  - redirect_valid is ignored in IDLE.
- fetch_count increments on every cycle with out_valid && out_ready, including a cycle that also carries a redirect. It wraps modulo 2^32.
- PC arithmetic is modulo 2^ADDR_W: pc=124 (0x7C) fetches and advances to 0.
- pc[1:0] is always 0 outside of reset misconfiguration. A RESET_PC with nonzero low bits is an illegal parameter; flag it with an elaboration-time check.
- run_en is level-sampled only in IDLE; deasserting it in RUN has no effect.

Decomposition:
- Shared package core_pkg:
  - fetch_state_t enum (IDLE, RUN, HALT)
  - constants XLEN=32, IMEM_ADDR_W=7, INSTR_BYTES=4
  - NOP_INSTR=32'h00000013 for use by decode on flush
- One natural sub-module, pc_reg: holds pc and selects among hold, pc+4 and redirect_pc, with reset to RESET_PC.
- Output slot, FSM and counter stay in fetch_stage.

Test Plan:
- Reset then run_en=1 with out_ready=1 and memory preloaded 0x00500093, 0x00a00113 at 0x00 and 0x04:
  - out_valid rises 2 cycles after run_en.
  - out_pc=0x00, out_instr=0x00500093, then out_pc=0x04, out_instr=0x00a00113.
  - fetch_count=2 after two accepted cycles.
- Backpressure: out_ready=0 for 3 cycles while out_pc=0x08:
  - out_instr/out_pc stay constant and r_addr_imem stays 0x0C.
  - After out_ready=1, the next out_pc=0x0C with no skipped or duplicated instruction.
- Redirect to 0x40 in the same cycle out_valid=1, out_ready=1:
  - fetch_count increments and out_valid=0 the next cycle.
  - The cycle after that gives out_pc=0x40.
- Wrap: redirect to 0x7C:
  - out_pc=0x7C, then out_pc=0x00, with r_addr_imem=0x00.
- Misaligned redirect to 0x22:
  - misalign_err=1 and state_o=2 next cycle, out_valid=0.
  - A later aligned redirect is ignored.
  - rst=1 clears misalign_err, state_o=0, pc=RESET_PC.
- Reset asserted mid-stall (out_valid=1, out_ready=0):
  - Next cycle all outputs are at reset values and fetch_count=0.
